// File: rtl/alarm_pkg.sv
// -----------------------------------------------------------------------------
// alarm_pkg
// Shared types and constants for the alarm annunciator:
//   alarm_state_t  - annunciator state (IDLE, RINGING, SNOOZE)
//   SNOOZE_COUNT_W - width of the per-event accepted-snooze counter
// -----------------------------------------------------------------------------
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } alarm_state_t;

    localparam int SNOOZE_COUNT_W = 3;

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronizes a raw active-low push-button into the clk domain, debounces it
// and emits a single-cycle pulse when the debounced key goes from released (1)
// to pressed (0). Releasing the key produces nothing.
//
// Ports:
//   clk        in   system clock
//   alarmreset in   asynchronous active-high reset
//   key_n      in   raw active-low key, asynchronous to clk
//   press      out  1-clk pulse on an accepted press
// -----------------------------------------------------------------------------
module key_debounce
    import alarm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic alarmreset,
    input  logic key_n,
    output logic press
);

    localparam int DEB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic             key_meta_reg;
    logic             key_sync_reg;
    logic             key_deb_reg;
    logic [DEB_W-1:0] deb_cnt_reg;
    logic             press_reg;

    // The counter tracks how many consecutive synchronized samples have
    // disagreed with the current debounced level. Any sample that agrees
    // again restarts it, so only a stable new level is ever accepted.
    always_ff @(posedge clk or posedge alarmreset) begin
        if (alarmreset) begin
            key_meta_reg <= 1'b0;
            key_sync_reg <= 1'b0;
            key_deb_reg  <= 1'b1;
            deb_cnt_reg  <= '0;
            press_reg    <= 1'b0;
        end else begin
            key_meta_reg <= key_n;
            key_sync_reg <= key_meta_reg;
            press_reg    <= 1'b0;
            if (key_sync_reg == key_deb_reg) begin
                deb_cnt_reg <= '0;
            end else if (deb_cnt_reg == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                key_deb_reg <= key_sync_reg;
                deb_cnt_reg <= '0;
                press_reg   <= ~key_sync_reg;
            end else begin
                deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/alarm_annunciator.sv
// -----------------------------------------------------------------------------
// alarm_annunciator
// Alarm ringing / snooze controller. A rising alarm_trig starts RINGING with a
// blinking LED; a debounced snooze press moves to SNOOZE (limited to
// MAX_SNOOZE per alarm event); timeouts are counted in 2 Hz tick pulses.
//
// Ports:
//   clk          in   system clock (50 MHz)
//   alarmreset   in   asynchronous active-high reset, also the user dismiss
//   tick         in   1-clk enable at 2 Hz
//   alarm_trig   in   alarm level, asynchronous to clk
//   snooze_n     in   raw active-low snooze key, asynchronous to clk
//   led_alarm    out  blinking alarm indicator
//   ringing      out  high while in RINGING
//   snoozing     out  high while in SNOOZE
//   snooze_count out  snoozes accepted for the current alarm event
// -----------------------------------------------------------------------------
module alarm_annunciator
    import alarm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RING_TICKS      = 120,
    parameter int SNOOZE_TICKS    = 600,
    parameter int MAX_SNOOZE      = 3
) (
    input  logic                      clk,
    input  logic                      alarmreset,
    input  logic                      tick,
    input  logic                      alarm_trig,
    input  logic                      snooze_n,
    output logic                      led_alarm,
    output logic                      ringing,
    output logic                      snoozing,
    output logic [SNOOZE_COUNT_W-1:0] snooze_count
);

    localparam int RING_W  = $clog2(RING_TICKS + 1);
    localparam int SNZ_W   = $clog2(SNOOZE_TICKS + 1);

    logic press;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk       (clk),
        .alarmreset(alarmreset),
        .key_n     (snooze_n),
        .press     (press)
    );

    // alarm_trig synchronizer and rising-edge detector. trig_valid_reg marks
    // when the synchronizer output carries a real sample; until then the edge
    // detector keeps its "previous" at 1, so a level already high at reset
    // release must fall before it can trigger again.
    logic       trig_meta_reg;
    logic       trig_sync_reg;
    logic [1:0] trig_valid_reg;
    logic       trig_prev_reg;
    logic       trig_rise;

    always_ff @(posedge clk or posedge alarmreset) begin
        if (alarmreset) begin
            trig_meta_reg  <= 1'b0;
            trig_sync_reg  <= 1'b0;
            trig_valid_reg <= 2'b00;
            trig_prev_reg  <= 1'b1;
        end else begin
            trig_meta_reg  <= alarm_trig;
            trig_sync_reg  <= trig_meta_reg;
            trig_valid_reg <= {trig_valid_reg[0], 1'b1};
            if (trig_valid_reg[1]) begin
                trig_prev_reg <= trig_sync_reg;
            end
        end
    end

    assign trig_rise = trig_valid_reg[1] & trig_sync_reg & ~trig_prev_reg;

    // Annunciator FSM
    alarm_state_t              state_reg,        state_next;
    logic [RING_W-1:0]         ring_cnt_reg,     ring_cnt_next;
    logic [SNZ_W-1:0]          snz_cnt_reg,      snz_cnt_next;
    logic [SNOOZE_COUNT_W-1:0] snooze_count_reg, snooze_count_next;
    logic                      led_reg,          led_next;
    logic [RING_W-1:0]         ring_inc;
    logic [SNZ_W-1:0]          snz_inc;

    assign ring_inc = ring_cnt_reg + RING_W'(1);
    assign snz_inc  = snz_cnt_reg + SNZ_W'(1);

    always_ff @(posedge clk or posedge alarmreset) begin
        if (alarmreset) begin
            state_reg        <= IDLE;
            ring_cnt_reg     <= '0;
            snz_cnt_reg      <= '0;
            snooze_count_reg <= '0;
            led_reg          <= 1'b0;
        end else begin
            state_reg        <= state_next;
            ring_cnt_reg     <= ring_cnt_next;
            snz_cnt_reg      <= snz_cnt_next;
            snooze_count_reg <= snooze_count_next;
            led_reg          <= led_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        ring_cnt_next     = ring_cnt_reg;
        snz_cnt_next      = snz_cnt_reg;
        snooze_count_next = snooze_count_reg;
        led_next          = led_reg;
        case (state_reg)
            IDLE: begin
                if (trig_rise) begin
                    state_next        = RINGING;
                    ring_cnt_next     = '0;
                    snooze_count_next = '0;
                    led_next          = 1'b1;
                end
            end
            RINGING: begin
                // An accepted press takes priority over the final ring tick.
                if (press && (snooze_count_reg < SNOOZE_COUNT_W'(MAX_SNOOZE))) begin
                    state_next        = SNOOZE;
                    snooze_count_next = snooze_count_reg + SNOOZE_COUNT_W'(1);
                    snz_cnt_next      = '0;
                    led_next          = 1'b0;
                end else if (tick) begin
                    ring_cnt_next = ring_inc;
                    led_next      = ~led_reg;
                    if (ring_inc == RING_W'(RING_TICKS)) begin
                        state_next = IDLE;
                        led_next   = 1'b0;
                    end
                end
            end
            SNOOZE: begin
                led_next = 1'b0;
                if (tick) begin
                    snz_cnt_next = snz_inc;
                    if (snz_inc == SNZ_W'(SNOOZE_TICKS)) begin
                        state_next    = RINGING;
                        ring_cnt_next = '0;
                        led_next      = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                led_next   = 1'b0;
            end
        endcase
    end

    assign led_alarm    = led_reg;
    assign ringing      = (state_reg == RINGING);
    assign snoozing     = (state_reg == SNOOZE);
    assign snooze_count = snooze_count_reg;

endmodule
